cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter for the common data bus: each cycle it picks one completed reservation station from the concatenated `complete` vectors (ALU, then other functional-unit stations) and drives the registered `selection`/`sel_load` pair. The station whose ID matches `selection` then places its result on the CDB. It sits between the per-unit reservation-station wrappers and the CDB mux/reorder buffer, and guarantees fairness and no double broadcast of the same station.

## Interface

- `NUM_REQ`, default 8: number of requesting stations; legal range 2..31.
- `BASE_ID`, default 1: `selection` value for requester 0. Requester i maps to `BASE_ID + i`, and `BASE_ID` equals `res_alu_1`. Value 0 is `res_invalid`.
- `clk` — input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` — input, 1 bit: reset, asynchronous and active-low.
- `req` — input, `NUM_REQ` bits: bit i = station i complete, i.e. result ready for broadcast.
- `stall` — input, 1 bit: CDB cannot accept this cycle; hold the current grant.
- `flush` — input, 1 bit: pipeline flush; synchronous cancel of any grant.
- `selection` — output, 32 bits: ID of the granted station, or 0 (`res_invalid`) when there is no grant.
- `sel_load` — output, 1 bit: `selection` is valid this cycle.
- `grant` — output, `NUM_REQ` bits: one-hot form of `selection`; all zeros when `sel_load` = 0.
- `grant_count` — output, 16 bits: number of grants issued; wraps modulo 2^16.

## Operation

- **State**
  - `ptr`: round-robin pointer, log2(`NUM_REQ`) bits.
  - `mask`: one-hot register of the last-granted station.
  - Output registers: `selection`, `sel_load`, `grant`, `grant_count`.
- **Reset** (`rst_n` = 0, asynchronous): `ptr` = 0, `mask` = 0, `selection` = 0, `sel_load` = 0, `grant` = 0, `grant_count` = 0.
- **Edge priority**, per rising edge, highest first: `flush`, then `stall`, then normal arbitration.
- **Flush**
  - Clears `sel_load`, `selection`, `grant` and `mask`.
  - `ptr` resets to 0.
  - `grant_count` is unchanged.
- **Stall** (no flush): every register holds its value. A granted station stays granted until the stall drops.
- **Normal arbitration**
  - `eligible = req & ~mask`.
  - The winner is the lowest index i ≥ `ptr` with `eligible[i]` set. If there is none, the search wraps to the lowest i < `ptr`.
  - Winner found:
    - `sel_load` ← 1, `selection` ← `BASE_ID + i` (zero-extended to 32 bits), `grant` ← one-hot(i), `mask` ← one-hot(i).
    - `ptr` ← (i + 1) mod `NUM_REQ`.
    - `grant_count` ← `grant_count` + 1, wrapping.
  - No winner: `sel_load` ← 0, `selection` ← 0, `grant` ← 0, `mask` ← 0; `ptr` holds.
- **Why `mask` exists:** a station deasserts `complete` one cycle after it is granted, because its entry is cleared on the finish edge. Masking it for exactly one arbitration prevents the same result being broadcast twice.
- **Sole remaining requester:** if the only request after a grant is the masked station, that cycle issues no grant. The station is re-eligible on the following cycle.
- **Idle requests:** a request that is low has no effect.
- **Request dropped during stall:** if a request deasserts while its grant is held under stall, the grant is still held. Resolving this is the upstream's responsibility, since stations hold `complete` until finished.

## Timing

- **Latency:** `req[i]` rising before edge N is visible as `sel_load`/`selection` after edge N. The arbiter adds one cycle from request to grant.
- **Output stability:** all outputs are registered and glitch-free for the whole cycle.
- **Throughput:** at most one grant per cycle.
- **Back-to-back grants:** two consecutive grants never go to the same station.
- **Fairness:** with all stations requesting continuously, each station is granted once every `NUM_REQ` cycles.
- **`grant_count` wrap:** 0xFFFF + 1 → 0x0000.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-grant, asynchronously → all outputs 0 immediately, before the next clock edge. Release; with `req` = 0 → `sel_load` = 0, `selection` = 0.
- **Single requester:** `req` = 8'b0000_0100 held for 4 cycles → `selection` sequence 3, 0, 3, 0 (`BASE_ID` = 1) with `sel_load` 1, 0, 1, 0; `grant_count` = 2.
- **Round robin:** `req` = 8'hFF held for 9 cycles → `selection` 1, 2, 3, 4, 5, 6, 7, 8, 1; `ptr` wraps after index 7.
- **Stall hold:** `req` = 8'h30, stall asserted on the cycle after the first grant → `selection` = 5 held for every stall cycle, `grant_count` unchanged; after stall drops → `selection` = 6.
- **Flush vs stall:** grant to station 2 is active (`selection` = 3); assert `flush` and `stall` together → next cycle `sel_load` = 0, `selection` = 0, `ptr` = 0; with `req` = 8'h81 the next grant has `selection` = 1.
- **Counter wrap:** preload by running 65535 grants, then one more → `grant_count` = 0x0000.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Handshake bundle between the reservation-station completion vectors and the CDB arbiter.
// The bench or upstream logic uses the master side. The arbiter uses the slave side.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 8
);
    logic [NUM_REQ-1:0] req;
    logic               stall;
    logic               flush;
    logic [31:0]        selection;
    logic               sel_load;
    logic [NUM_REQ-1:0] grant;
    logic [15:0]        grant_count;

    modport master (
        output req, stall, flush,
        input  selection, sel_load, grant, grant_count
    );

    modport slave (
        input  req, stall, flush,
        output selection, sel_load, grant, grant_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: each cycle it grants one completed station.
// A one-cycle mask blocks the station granted last so its result is not broadcast twice.
module cdb_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int BASE_ID = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_p1;
    logic [NUM_REQ-1:0] mask_p1;
    logic [31:0]        selection_p1;
    logic               vld_p1;
    logic [NUM_REQ-1:0] grant_p1;
    logic [15:0]        count_p1;

    logic [NUM_REQ-1:0] eligible_p0;
    logic               hi_vld_p0;
    logic               lo_vld_p0;
    logic [PTR_W-1:0]   hi_idx_p0;
    logic [PTR_W-1:0]   lo_idx_p0;
    logic               win_vld_p0;
    logic [PTR_W-1:0]   win_idx_p0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1)
            return '0;
        return idx + PTR_W'(1);
    endfunction

    // Stage p0: select the winner from the requests and the registered ptr/mask.
    // The loop scans from the top index down, so the last match it keeps is the lowest index.
    always_comb begin
        eligible_p0 = bus.req & ~mask_p1;
        hi_vld_p0   = 1'b0;
        lo_vld_p0   = 1'b0;
        hi_idx_p0   = '0;
        lo_idx_p0   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible_p0[i]) begin
                if (PTR_W'(i) >= ptr_p1) begin
                    hi_vld_p0 = 1'b1;
                    hi_idx_p0 = PTR_W'(i);
                end else begin
                    lo_vld_p0 = 1'b1;
                    lo_idx_p0 = PTR_W'(i);
                end
            end
        end
        win_vld_p0 = hi_vld_p0 | lo_vld_p0;
        win_idx_p0 = hi_vld_p0 ? hi_idx_p0 : lo_idx_p0;
    end

    // Stage p1: registered grant outputs. Flush takes priority over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p1       <= '0;
            mask_p1      <= '0;
            selection_p1 <= '0;
            vld_p1       <= 1'b0;
            grant_p1     <= '0;
            count_p1     <= '0;
        end else if (bus.flush) begin
            ptr_p1       <= '0;
            mask_p1      <= '0;
            selection_p1 <= '0;
            vld_p1       <= 1'b0;
            grant_p1     <= '0;
        end else if (!bus.stall) begin
            if (win_vld_p0) begin
                ptr_p1       <= next_ptr(win_idx_p0);
                mask_p1      <= NUM_REQ'(1) << win_idx_p0;
                grant_p1     <= NUM_REQ'(1) << win_idx_p0;
                selection_p1 <= 32'(BASE_ID + int'(win_idx_p0));
                vld_p1       <= 1'b1;
                count_p1     <= count_p1 + 16'd1;
            end else begin
                mask_p1      <= '0;
                grant_p1     <= '0;
                selection_p1 <= '0;
                vld_p1       <= 1'b0;
            end
        end
    end

    assign bus.selection   = selection_p1;
    assign bus.sel_load    = vld_p1;
    assign bus.grant       = grant_p1;
    assign bus.grant_count = count_p1;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter that checks the DUT every cycle against a round-robin
// reference model, plus literal expectations for the reset, single, round-robin, stall,
// flush and wrap cases.
module tb_cdb_arbiter;
    localparam int N    = 8;
    localparam int BASE = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    cdb_arbiter_if #(.NUM_REQ(N)) bus ();

    cdb_arbiter #(.NUM_REQ(N), .BASE_ID(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state. m_last is the station granted on the previous cycle, or -1 for none.
    int          m_ptr  = 0;
    int          m_last = -1;
    logic        m_load = 1'b0;
    logic [31:0] m_sel  = '0;
    logic [N-1:0] m_grant = '0;
    logic [15:0] m_cnt  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 0; m_last <= -1; m_load <= 0; m_sel <= 0; m_grant <= 0; m_cnt <= 0;
        end else if (bus.flush) begin
            m_ptr <= 0; m_last <= -1; m_load <= 0; m_sel <= 0; m_grant <= 0;
        end else if (!bus.stall) begin
            automatic int w = -1;
            for (int k = 0; k < N; k++) begin
                automatic int idx = (m_ptr + k) % N;
                if (w < 0 && bus.req[idx] && idx != m_last) w = idx;
            end
            if (w >= 0) begin
                m_load  <= 1'b1;
                m_sel   <= 32'(BASE + w);
                m_grant <= N'(1) << w;
                m_last  <= w;
                m_ptr   <= (w + 1) % N;
                m_cnt   <= m_cnt + 16'd1;
            end else begin
                m_load <= 0; m_sel <= 0; m_grant <= 0; m_last <= -1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_sel_load",    32'(bus.sel_load),    32'(m_load));
        chk("model_selection",   bus.selection,        m_sel);
        chk("model_grant",       32'(bus.grant),       32'(m_grant));
        chk("model_grant_count", 32'(bus.grant_count), 32'(m_cnt));
    end

    // Advance one clock. On return the outputs of that edge are stable.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp_rr[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 1};

    initial begin
        bus.req = '0; bus.stall = 0; bus.flush = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("reset_sel_load", 32'(bus.sel_load), 0);
        chk("reset_selection", bus.selection, 0);

        // Single requester: the mask forces alternating grant/no-grant.
        bus.req = 8'b0000_0100;
        step(); chk("single_sel0", bus.selection, 3); chk("single_load0", 32'(bus.sel_load), 1);
        step(); chk("single_sel1", bus.selection, 0); chk("single_load1", 32'(bus.sel_load), 0);
        step(); chk("single_sel2", bus.selection, 3);
        step(); chk("single_sel3", bus.selection, 0);
        chk("single_count", 32'(bus.grant_count), 2);

        // Round robin from a flushed pointer.
        bus.req = 8'hFF; bus.flush = 1;
        step(); bus.flush = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rr_sel%0d", i), bus.selection, exp_rr[i]);
        end

        // Stall holds the grant and the count.
        bus.flush = 1; step(); bus.flush = 0;
        bus.req = 8'h30;
        step(); chk("stall_first", bus.selection, 5);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_hold%0d", i), bus.selection, 5);
            chk($sformatf("stall_cnt%0d", i), 32'(bus.grant_count), 12);
        end
        bus.stall = 0;
        step(); chk("stall_release", bus.selection, 6);

        // Flush wins over stall and resets the pointer.
        bus.flush = 1; step(); bus.flush = 0;
        bus.req = 8'h04;
        step(); chk("fs_grant", bus.selection, 3);
        bus.flush = 1; bus.stall = 1;
        step(); chk("fs_sel", bus.selection, 0); chk("fs_load", 32'(bus.sel_load), 0);
        bus.flush = 0; bus.stall = 0; bus.req = 8'h81;
        step(); chk("fs_next", bus.selection, 1);

        // Asynchronous reset in the middle of a grant.
        bus.req = 8'hFF;
        step(); chk("areset_pre", 32'(bus.sel_load), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_load", 32'(bus.sel_load), 0);
        chk("areset_sel", bus.selection, 0);
        chk("areset_grant", 32'(bus.grant), 0);
        chk("areset_cnt", 32'(bus.grant_count), 0);
        bus.req = '0;
        @(negedge clk); rst_n = 1'b1;
        step(); chk("areset_idle_load", 32'(bus.sel_load), 0); chk("areset_idle_sel", bus.selection, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.req   = (i % 3 == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
            bus.stall = ($urandom_range(7) == 0);
            bus.flush = ($urandom_range(15) == 0);
            step();
        end
        bus.stall = 0; bus.flush = 0; bus.req = '0;

        // Counter wrap after a fresh reset.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        bus.req = 8'hFF;
        repeat (65535) step();
        chk("wrap_full", 32'(bus.grant_count), 32'hFFFF);
        step();
        chk("wrap_zero", 32'(bus.grant_count), 0);

        bus.req = '0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
